ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal ps2c samples required to accept a level change.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000: clk cycles without an accepted ps2c falling edge mid-frame before the frame aborts.
REQ-003 clk  input  1  system clock (100 MHz); all logic on rising edge.
REQ-004 clr  input  1  reset; synchronous, active-low.
REQ-005 ps2c  input  1  PS/2 clock from keyboard, asynchronous.
REQ-006 ps2d  input  1  PS/2 data from keyboard, asynchronous.
REQ-007 status  output  4  held key state: bit0 up, bit1 down, bit2 left, bit3 right; feeds the game controller.
REQ-008 scan_code  output  8  last received byte.
REQ-009 code_valid  output  1  one-cycle pulse; scan_code is new.
REQ-010 frame_err  output  1  one-cycle pulse; frame rejected.

Function
REQ-011 ps2c and ps2d SHALL each pass through a 2-flop synchronizer before use.
REQ-012 Filtered ps2c SHALL change only after FILTER_LEN consecutive equal synchronized samples; a falling edge of the filtered ps2c is "fall".
REQ-013 Receiver FSM SHALL have states IDLE, DATA, PARITY, STOP; ps2d is sampled only on cycles with fall.
REQ-014 IDLE: fall with ps2d=0 -> DATA, bit count 0; fall with ps2d=1 -> stay IDLE, no error.
REQ-015 DATA: shift ps2d in LSB-first on each fall; after the 8th bit -> PARITY.
REQ-016 PARITY: capture ps2d on fall -> STOP.
REQ-017 STOP: on fall, ps2d=1 and parity OK -> accept byte, IDLE; else frame_err pulse, IDLE.
REQ-018 Parity OK SHALL mean the 8 data bits plus the parity bit contain an odd number of ones.
REQ-019 Accepted byte: scan_code updated and code_valid high in the cycle after the stop-bit fall.
REQ-020 In DATA/PARITY/STOP, TIMEOUT_CYC cycles without fall SHALL abort to IDLE with one frame_err pulse; the counter restarts on every fall.
REQ-021 Decoder SHALL keep flags ext (set on 0xE0) and brk (set on 0xF0); prefix bytes change no status bit.
REQ-022 On any other accepted byte with ext=1: 0x75->bit0, 0x72->bit1, 0x6B->bit2, 0x74->bit3; bit set if brk=0, cleared if brk=1; then ext and brk cleared.
REQ-023 Non-prefix byte with ext=0, or an unmapped extended code, SHALL clear ext and brk and leave status unchanged.
REQ-024 status SHALL update in the cycle after code_valid (2 cycles after stop-bit fall).
REQ-025 A frame_err SHALL clear ext and brk; status is unchanged.
REQ-026 Multiple keys MAY be held; each bit is independent; repeated make codes leave a set bit set.
REQ-027 code_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-028 With clr=0 at a rising edge: FSM IDLE, counters 0, ext=brk=0, status=0, scan_code=0x00, code_valid=0, frame_err=0; filter and synchronizers are preset to 1 (idle bus).
REQ-029 Reset mid-frame SHALL discard the partial frame with no pulse; the next frame starts cleanly after clr returns to 1.

Configuration
REQ-030 Macro PS2_PARITY_CHECK_EN defined: REQ-017/018 apply in full.
REQ-031 Macro undefined: the parity bit is captured but ignored; only a bad stop bit or a timeout raises frame_err.

Structure
REQ-032 Shared package br_pkg SHALL hold the scancode constants (0xE0, 0xF0, 0x75, 0x72, 0x6B, 0x74), status bit indices, and the receiver state enum.
REQ-033 Sub-module ps2_rx SHALL hold the synchronizer, filter, receiver FSM and timeout; it outputs the byte, valid and error signals. Prefix/status logic sits in ps2_key_decoder.

Verification
REQ-034 Frame 0xE0 then 0x75, valid parity -> code_valid twice, scan_code 0x75, status=4'b0001.
REQ-035 Then E0,F0,75 -> status=4'b0000; E0,6B plus E0,74 -> status=4'b1100.
REQ-036 Byte 0x1C sent with even parity -> frame_err pulse, no code_valid, status unchanged; with macro undefined -> code_valid, scan_code 0x1C.
REQ-037 Stop bit driven 0 -> frame_err; the next good E0,72 frame pair -> status bit1=1.
REQ-038 Stop ps2c after 4 data bits for TIMEOUT_CYC cycles -> exactly one frame_err; the next full frame decodes correctly.
REQ-039 Glitch on ps2c shorter than FILTER_LEN cycles -> no bit shifted. clr=0 mid-frame -> all outputs 0, no pulse.

Source files
------------

// File: rtl/br_pkg.sv
// Shared constants for the PS/2 arrow-key decoder: scancodes, status bit
// indices, receiver state encoding and the arrow-key mask helper.
package br_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int unsigned ST_UP    = 0;
    localparam int unsigned ST_DOWN  = 1;
    localparam int unsigned ST_LEFT  = 2;
    localparam int unsigned ST_RIGHT = 3;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // One-hot status mask for an extended arrow code; zero for anything else.
    function automatic logic [3:0] key_mask(input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        case (code)
            SC_UP:    m[ST_UP]    = 1'b1;
            SC_DOWN:  m[ST_DOWN]  = 1'b1;
            SC_LEFT:  m[ST_LEFT]  = 1'b1;
            SC_RIGHT: m[ST_RIGHT] = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Keyboard-facing bundle of the PS/2 arrow-key decoder: raw PS/2 lines in,
// decoded byte, pulses and held-key status out.
interface ps2_key_decoder_if;

    logic       ps2c;
    logic       ps2d;
    logic [3:0] status;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       frame_err;

    modport master (
        output ps2c, ps2d,
        input  status, scan_code, code_valid, frame_err
    );

    modport slave (
        input  ps2c, ps2d,
        output status, scan_code, code_valid, frame_err
    );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, ps2c glitch filter, frame FSM, timeout.
// Parity is enforced only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx
    import br_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    c_sync;
    logic [1:0]    d_sync;
    logic          c_filt;
    logic [FW-1:0] f_cnt;
    logic          fall;

    rx_state_t     state;
    rx_state_t     state_d;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic          par_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          par_ok;
    logic          shift_en;
    logic          cap_par;
    logic          bit_clr;
    logic          accept;
    logic          fail;

    // The filter flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk) begin
        if (!clr) begin
            c_sync <= '1;
            d_sync <= '1;
            c_filt <= 1'b1;
            f_cnt  <= '0;
            fall   <= 1'b0;
        end else begin
            c_sync <= {c_sync[0], ps2c};
            d_sync <= {d_sync[0], ps2d};
            fall   <= 1'b0;
            if (c_sync[1] == c_filt) begin
                f_cnt <= '0;
            end else if (f_cnt == FW'(FILTER_LEN - 1)) begin
                c_filt <= c_sync[1];
                f_cnt  <= '0;
                fall   <= c_filt;
            end else begin
                f_cnt <= f_cnt + 1'b1;
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    assign par_ok = ^{shift_q, par_q};
`else
    // Parity bit is still captured; the OR keeps it structurally referenced.
    assign par_ok = 1'b1 | (^{shift_q, par_q});
`endif

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d  = state;
        shift_en = 1'b0;
        cap_par  = 1'b0;
        bit_clr  = 1'b0;
        accept   = 1'b0;
        fail     = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !d_sync[1]) begin
                    state_d = DATA;
                    bit_clr = 1'b1;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_d = PARITY;
                end else if (tmo_hit) begin
                    fail    = 1'b1;
                    state_d = IDLE;
                end
            end
            PARITY: begin
                if (fall) begin
                    cap_par = 1'b1;
                    state_d = STOP;
                end else if (tmo_hit) begin
                    fail    = 1'b1;
                    state_d = IDLE;
                end
            end
            STOP: begin
                if (fall) begin
                    if (d_sync[1] && par_ok) accept = 1'b1;
                    else                     fail   = 1'b1;
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    fail    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= IDLE;
            shift_q  <= '0;
            bit_cnt  <= '0;
            par_q    <= 1'b0;
            tmo_cnt  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            state    <= state_d;
            rx_valid <= accept;
            rx_err   <= fail;
            if (bit_clr)  bit_cnt <= '0;
            if (shift_en) begin
                shift_q <= {d_sync[1], shift_q[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (cap_par) par_q <= d_sync[1];
            if (accept)  rx_byte <= shift_q;
            if (state == IDLE || fall) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 arrow-key decoder top: ps2_rx plus E0/F0 prefix tracking and held-key
// status. Build macro PS2_PARITY_CHECK_EN enables odd-parity rejection.
module ps2_key_decoder
    import br_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 8,
    parameter int unsigned TIMEOUT_CYC = 200000
) (
    input  logic              clk,
    input  logic              clr,
    ps2_key_decoder_if.slave  kbd
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;
    logic [3:0] status_q;
    logic [3:0] mask;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .clr      (clr),
        .ps2c     (kbd.ps2c),
        .ps2d     (kbd.ps2d),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_err   (rx_err)
    );

    assign mask = ext ? key_mask(rx_byte) : 4'b0000;

    always_ff @(posedge clk) begin
        if (!clr) begin
            ext      <= 1'b0;
            brk      <= 1'b0;
            status_q <= '0;
        end else if (rx_err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext <= 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk <= 1'b1;
            end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                status_q <= brk ? (status_q & ~mask) : (status_q | mask);
            end
        end
    end

    assign kbd.status     = status_q;
    assign kbd.scan_code  = rx_byte;
    assign kbd.code_valid = rx_valid;
    assign kbd.frame_err  = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: frames, prefixes, errors, timeout,
// glitch rejection and mid-frame reset.
module tb_ps2_key_decoder;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    int   n_valid;
    int   n_err;
    int   n_both;
    logic [7:0] last_code;

    ps2_key_decoder_if kbd ();

    ps2_key_decoder #(
        .FILTER_LEN  (8),
        .TIMEOUT_CYC (2000)
    ) dut (
        .clk (clk),
        .clr (clr),
        .kbd (kbd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (kbd.code_valid) begin
            n_valid   = n_valid + 1;
            last_code = kbd.scan_code;
        end
        if (kbd.frame_err) n_err = n_err + 1;
        if (kbd.code_valid && kbd.frame_err) n_both = n_both + 1;
    end

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // nbits < 11 sends a truncated frame; glitch injects a 4-cycle low blip on bit 4
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int unsigned nbits, input bit glitch, input int unsigned gap);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = b;
        bits[9]   = bad_par ? (^b) : ~(^b);
        bits[10]  = ~bad_stop;
        for (int unsigned i = 0; i < nbits; i++) begin
            kbd.ps2d = bits[i];
            if (glitch && i == 4) begin
                wait_cyc(10);
                kbd.ps2c = 1'b0;
                wait_cyc(4);
                kbd.ps2c = 1'b1;
                wait_cyc(11);
            end else begin
                wait_cyc(25);
            end
            kbd.ps2c = 1'b0;
            wait_cyc(50);
            kbd.ps2c = 1'b1;
            wait_cyc(25);
        end
        kbd.ps2d = 1'b1;
        wait_cyc(gap);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11, 1'b0, 100);
    endtask

    task automatic test_reset;
        clr = 1'b0;
        wait_cyc(5);
        checks++;
        if (kbd.status !== 4'b0000) begin
            failures++;
            $display("FAIL reset_status actual=%b expected=0000", kbd.status);
        end
        checks++;
        if (kbd.scan_code !== 8'h00) begin
            failures++;
            $display("FAIL reset_scan_code actual=%h expected=00", kbd.scan_code);
        end
        checks++;
        if ({kbd.code_valid, kbd.frame_err} !== 2'b00) begin
            failures++;
            $display("FAIL reset_pulses actual=%b expected=00", {kbd.code_valid, kbd.frame_err});
        end
        clr = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_make;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_byte(8'hE0);
        send_byte(8'h75);
        checks++;
        if (n_valid - v0 !== 2) begin
            failures++;
            $display("FAIL make_valid_count actual=%0d expected=2", n_valid - v0);
        end
        checks++;
        if (n_err - e0 !== 0) begin
            failures++;
            $display("FAIL make_err_count actual=%0d expected=0", n_err - e0);
        end
        checks++;
        if (last_code !== 8'h75 || kbd.scan_code !== 8'h75) begin
            failures++;
            $display("FAIL make_scan_code actual=%h/%h expected=75", last_code, kbd.scan_code);
        end
        checks++;
        if (kbd.status !== 4'b0001) begin
            failures++;
            $display("FAIL make_status actual=%b expected=0001", kbd.status);
        end
    endtask

    task automatic test_break_multi;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        checks++;
        if (kbd.status !== 4'b0000) begin
            failures++;
            $display("FAIL break_status actual=%b expected=0000", kbd.status);
        end
        send_byte(8'hE0); send_byte(8'h6B);
        send_byte(8'hE0); send_byte(8'h74);
        checks++;
        if (kbd.status !== 4'b1100) begin
            failures++;
            $display("FAIL multi_status actual=%b expected=1100", kbd.status);
        end
    endtask

    task automatic test_parity;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0, 100);
`ifdef PS2_PARITY_CHECK_EN
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL parity_pulses actual=err%0d/valid%0d expected=err1/valid0", n_err - e0, n_valid - v0);
        end
`else
        checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 1 || last_code !== 8'h1C) begin
            failures++;
            $display("FAIL parity_ignored actual=err%0d/valid%0d/%h expected=err0/valid1/1c", n_err - e0, n_valid - v0, last_code);
        end
`endif
        checks++;
        if (kbd.status !== 4'b1100) begin
            failures++;
            $display("FAIL parity_status actual=%b expected=1100", kbd.status);
        end
    endtask

    task automatic test_stop_bit;
        int v0, e0;
        send_byte(8'hE0); send_byte(8'hF0);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h74, 1'b0, 1'b1, 11, 1'b0, 100);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL stop_pulses actual=err%0d/valid%0d expected=err1/valid0", n_err - e0, n_valid - v0);
        end
        // prefixes were dropped by the error, so a bare 74 must not touch status
        send_byte(8'h74);
        checks++;
        if (kbd.status !== 4'b1100) begin
            failures++;
            $display("FAIL stop_prefix_clear actual=%b expected=1100", kbd.status);
        end
        send_byte(8'hE0); send_byte(8'h72);
        checks++;
        if (kbd.status !== 4'b1110) begin
            failures++;
            $display("FAIL stop_recover actual=%b expected=1110", kbd.status);
        end
    endtask

    task automatic test_timeout;
        int v0, e0;
        v0 = n_valid; e0 = n_err;
        send_frame(8'h6B, 1'b0, 1'b0, 5, 1'b0, 2500);
        checks++;
        if (n_err - e0 !== 1 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL timeout_pulses actual=err%0d/valid%0d expected=err1/valid0", n_err - e0, n_valid - v0);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h6B);
        checks++;
        if (kbd.status !== 4'b1010 || kbd.scan_code !== 8'h6B) begin
            failures++;
            $display("FAIL timeout_recover actual=%b/%h expected=1010/6b", kbd.status, kbd.scan_code);
        end
    endtask

    task automatic test_glitch;
        int e0;
        e0 = n_err;
        send_frame(8'hE0, 1'b0, 1'b0, 11, 1'b1, 100);
        send_byte(8'hF0); send_byte(8'h72);
        checks++;
        if (kbd.status !== 4'b1000 || n_err - e0 !== 0) begin
            failures++;
            $display("FAIL glitch_status actual=%b/err%0d expected=1000/err0", kbd.status, n_err - e0);
        end
    endtask

    task automatic test_reset_mid;
        int v0, e0;
        send_byte(8'hE0);
        v0 = n_valid; e0 = n_err;
        send_frame(8'h75, 1'b0, 1'b0, 5, 1'b0, 0);
        clr = 1'b0;
        wait_cyc(10);
        checks++;
        if (kbd.status !== 4'b0000 || kbd.scan_code !== 8'h00 ||
            kbd.code_valid !== 1'b0 || kbd.frame_err !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs actual=%b/%h/%b%b expected=0000/00/00",
                     kbd.status, kbd.scan_code, kbd.code_valid, kbd.frame_err);
        end
        clr = 1'b1;
        wait_cyc(2500);
        checks++;
        if (n_err - e0 !== 0 || n_valid - v0 !== 0) begin
            failures++;
            $display("FAIL midreset_pulses actual=err%0d/valid%0d expected=err0/valid0", n_err - e0, n_valid - v0);
        end
        send_byte(8'h74);
        send_byte(8'hE0); send_byte(8'h74);
        checks++;
        if (kbd.status !== 4'b1000) begin
            failures++;
            $display("FAIL midreset_recover actual=%b expected=1000", kbd.status);
        end
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = n_valid;
        send_frame(8'hE0, 1'b0, 1'b0, 11, 1'b0, 0);
        send_frame(8'h75, 1'b0, 1'b0, 11, 1'b0, 0);
        send_frame(8'hE0, 1'b0, 1'b0, 11, 1'b0, 0);
        send_frame(8'h72, 1'b0, 1'b0, 11, 1'b0, 0);
        send_frame(8'hE0, 1'b0, 1'b0, 11, 1'b0, 0);
        send_frame(8'h75, 1'b0, 1'b0, 11, 1'b0, 100);
        checks++;
        if (n_valid - v0 !== 6 || kbd.scan_code !== 8'h75) begin
            failures++;
            $display("FAIL b2b_valid actual=%0d/%h expected=6/75", n_valid - v0, kbd.scan_code);
        end
        checks++;
        if (kbd.status !== 4'b1011) begin
            failures++;
            $display("FAIL b2b_status actual=%b expected=1011", kbd.status);
        end
        checks++;
        if (n_both !== 0) begin
            failures++;
            $display("FAIL pulse_overlap actual=%0d expected=0", n_both);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        n_valid   = 0;
        n_err     = 0;
        n_both    = 0;
        last_code = 8'h00;
        clr       = 1'b0;
        kbd.ps2c  = 1'b1;
        kbd.ps2d  = 1'b1;
        test_reset();
        test_make();
        test_break_multi();
        test_parity();
        test_stop_bit();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
